// File: rtl/efuse_load_ctrl.sv
// Efuse load sequencer: request/done handshake, image capture, per-attempt timeout with bounded retry.
// Latency: start -> req +1, vld +2, idle +4 with a 1-cycle IP; no backpressure, starts outside IDLE/ERR dropped.
module efuse_load_ctrl #(
    parameter int DATA_NUM    = 8,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_LOAD   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_load_start,
    output logic                          o_efuse_load_req,
    input  logic                          i_efuse_load_done,
    input  logic                          i_efuse_reg_update,
    input  logic [DATA_NUM*DW-1:0]        i_efuse_reg_data,
    output logic [DATA_NUM*DW-1:0]        o_efuse_data,
    output logic                          o_efuse_data_vld,
    output logic                          o_busy,
    output logic                          o_load_err,
    output logic [$clog2(MAX_RETRY+2)-1:0] o_retry_cnt
);
    localparam int IW = DATA_NUM * DW;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_ERR} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_auto_pend, w_auto_pend_nxt;
    logic            r_upd_seen, w_upd_seen_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [IW-1:0]   r_data, w_data_nxt;
    logic            r_vld, w_vld_nxt;
    logic [RW-1:0]   r_retry, w_retry_nxt;
    logic            r_req, r_busy, r_err;
    logic            w_start_load;

    assign o_efuse_load_req = r_req;
    assign o_efuse_data     = r_data;
    assign o_efuse_data_vld = r_vld;
    assign o_busy           = r_busy;
    assign o_load_err       = r_err;
    assign o_retry_cnt      = r_retry;

    always_comb begin
        w_state_nxt     = r_state;
        w_auto_pend_nxt = r_auto_pend;
        w_upd_seen_nxt  = r_upd_seen;
        w_timer_nxt     = r_timer;
        w_data_nxt      = r_data;
        w_vld_nxt       = r_vld;
        w_retry_nxt     = r_retry;
        w_start_load    = 1'b0;

        case (r_state)
            S_IDLE: w_start_load = r_auto_pend | i_load_start;
            S_ERR:  w_start_load = i_load_start;
            S_REQ: begin
                w_timer_nxt = r_timer + TW'(1);
                if (i_efuse_reg_update) begin
                    w_data_nxt     = i_efuse_reg_data;
                    w_upd_seen_nxt = 1'b1;
                end
                if (i_efuse_load_done) begin
                    w_state_nxt = S_RELEASE;
                    if (r_upd_seen | i_efuse_reg_update)
                        w_vld_nxt = 1'b1;
                    else
                        w_retry_nxt = r_retry + RW'(1);
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = S_RELEASE;
                    w_retry_nxt = r_retry + RW'(1);
                end
            end
            S_RELEASE: begin
                // A set vld here can only mean the attempt just finished succeeded.
                if (!i_efuse_load_done) begin
                    if (r_vld) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_retry <= RW'(MAX_RETRY)) begin
                        w_state_nxt    = S_REQ;
                        w_timer_nxt    = '0;
                        w_upd_seen_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_start_load) begin
            w_state_nxt     = S_REQ;
            w_auto_pend_nxt = 1'b0;
            w_vld_nxt       = 1'b0;
            w_retry_nxt     = '0;
            w_timer_nxt     = '0;
            w_upd_seen_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_auto_pend <= (AUTO_LOAD != 0);
            r_upd_seen  <= 1'b0;
            r_timer     <= '0;
            r_data      <= '0;
            r_vld       <= 1'b0;
            r_retry     <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_auto_pend <= w_auto_pend_nxt;
            r_upd_seen  <= w_upd_seen_nxt;
            r_timer     <= w_timer_nxt;
            r_data      <= w_data_nxt;
            r_vld       <= w_vld_nxt;
            r_retry     <= w_retry_nxt;
            r_req       <= (w_state_nxt == S_REQ);
            r_busy      <= (w_state_nxt == S_REQ) || (w_state_nxt == S_RELEASE);
            r_err       <= (w_state_nxt == S_ERR);
        end
    end
endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Directed bench for efuse_load_ctrl: per-cycle vector table on a default instance,
// plus a short-timeout instance for retry exhaustion and hand sequences for restart and async reset.
module tb_efuse_load_ctrl;
    localparam logic        B0 = 1'b0;
    localparam logic        B1 = 1'b1;
    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] D  = 64'hA5A5_0123_4567_89AB;
    localparam logic [63:0] E  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] F  = 64'hDEAD_BEEF_0000_FFFF;
    localparam int          NV = 22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, done, upd;
    logic [63:0] din;
    logic        req, vld, busy, err;
    logic [63:0] dout;
    logic [2:0]  rty;

    logic        b_start;
    logic        b_req, b_vld, b_busy, b_err;
    logic [63:0] b_dout;
    logic [1:0]  b_rty;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    efuse_load_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(start),
        .o_efuse_load_req(req), .i_efuse_load_done(done),
        .i_efuse_reg_update(upd), .i_efuse_reg_data(din),
        .o_efuse_data(dout), .o_efuse_data_vld(vld), .o_busy(busy),
        .o_load_err(err), .o_retry_cnt(rty)
    );

    efuse_load_ctrl #(.TIMEOUT_CYC(4), .MAX_RETRY(2), .AUTO_LOAD(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(b_start),
        .o_efuse_load_req(b_req), .i_efuse_load_done(1'b0),
        .i_efuse_reg_update(1'b0), .i_efuse_reg_data(64'h0),
        .o_efuse_data(b_dout), .o_efuse_data_vld(b_vld), .o_busy(b_busy),
        .o_load_err(b_err), .o_retry_cnt(b_rty)
    );

    typedef struct {
        logic        st, dn, up;
        logic [63:0] dat;
        logic        req, vld, busy, err;
        logic [2:0]  rty;
        logic [63:0] odat;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input int idx, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [79:0] main_outs();
        return {9'b0, req, vld, busy, err, rty, dout};
    endfunction

    initial begin
        int pulses, cur, bad_w;
        // fields: start done upd data | req vld busy err retry data
        tbl[0]  = '{B0, B0, B0, Z, B1, B0, B1, B0, 3'd0, Z};
        tbl[1]  = '{B0, B0, B0, Z, B1, B0, B1, B0, 3'd0, Z};
        tbl[2]  = '{B0, B1, B1, Z, B0, B1, B1, B0, 3'd0, Z};
        tbl[3]  = '{B0, B1, B0, Z, B0, B1, B1, B0, 3'd0, Z};
        tbl[4]  = '{B0, B0, B0, Z, B0, B1, B0, B0, 3'd0, Z};
        tbl[5]  = '{B0, B0, B1, F, B0, B1, B0, B0, 3'd0, Z};
        tbl[6]  = '{B1, B0, B0, Z, B1, B0, B1, B0, 3'd0, Z};
        tbl[7]  = '{B0, B0, B0, Z, B1, B0, B1, B0, 3'd0, Z};
        tbl[8]  = '{B0, B1, B1, D, B0, B1, B1, B0, 3'd0, D};
        tbl[9]  = '{B0, B1, B0, Z, B0, B1, B1, B0, 3'd0, D};
        tbl[10] = '{B0, B0, B0, Z, B0, B1, B0, B0, 3'd0, D};
        tbl[11] = '{B1, B0, B0, Z, B1, B0, B1, B0, 3'd0, D};
        tbl[12] = '{B0, B1, B0, Z, B0, B0, B1, B0, 3'd1, D};
        tbl[13] = '{B0, B0, B0, Z, B1, B0, B1, B0, 3'd1, D};
        tbl[14] = '{B0, B0, B1, E, B1, B0, B1, B0, 3'd1, E};
        tbl[15] = '{B0, B1, B0, Z, B0, B1, B1, B0, 3'd1, E};
        tbl[16] = '{B0, B0, B0, Z, B0, B1, B0, B0, 3'd1, E};
        tbl[17] = '{B1, B0, B0, Z, B1, B0, B1, B0, 3'd0, E};
        tbl[18] = '{B1, B0, B0, Z, B1, B0, B1, B0, 3'd0, E};
        tbl[19] = '{B1, B1, B1, D, B0, B1, B1, B0, 3'd0, D};
        tbl[20] = '{B1, B0, B0, Z, B0, B1, B0, B0, 3'd0, D};
        tbl[21] = '{B0, B0, B0, Z, B0, B1, B0, B0, 3'd0, D};

        rst_n = 1'b0; start = 1'b0; done = 1'b0; upd = 1'b0; din = '0; b_start = 1'b0;
        #2;
        chk("reset_main", 0, main_outs(), 80'h0);
        chk("reset_b", 0, {9'b0, b_req, b_vld, b_busy, b_err, 1'b0, b_rty, b_dout}, 80'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            start = tbl[i].st; done = tbl[i].dn; upd = tbl[i].up; din = tbl[i].dat;
            @(posedge clk);
            #1;
            chk("vec", i, main_outs(),
                {9'b0, tbl[i].req, tbl[i].vld, tbl[i].busy, tbl[i].err, tbl[i].rty, tbl[i].odat});
            @(negedge clk);
        end
        start = 1'b0; done = 1'b0; upd = 1'b0; din = '0;

        // Retry exhaustion with done never arriving: three 4-cycle request pulses, then error.
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        pulses = 0; cur = 0; bad_w = 0;
        for (int c = 0; c < 25; c++) begin
            if (b_req) begin
                cur++;
            end else if (cur > 0) begin
                pulses++;
                if (cur != 4) bad_w++;
                cur = 0;
            end
            @(posedge clk);
            #1;
        end
        chk("t3_pulses", 0, 80'(pulses), 80'd3);
        chk("t3_bad_width", 0, 80'(bad_w), 80'd0);
        chk("t3_err", 0, 80'(b_err), 80'd1);
        chk("t3_retry", 0, 80'(b_rty), 80'd3);
        chk("t3_busy", 0, 80'(b_busy), 80'd0);
        chk("t3_vld", 0, 80'(b_vld), 80'd0);

        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        chk("err_restart", 0, {76'b0, b_req, b_busy, b_err, b_rty == 2'd0}, {76'b0, 4'b1101});

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_req_before_rst", 0, 80'(req), 80'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", 0, main_outs(), 80'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_auto_req", 0, {78'b0, req, busy}, {78'b0, 2'b11});
        @(negedge clk);
        done = 1'b1; upd = 1'b1; din = E;
        @(posedge clk);
        #1;
        chk("t6_capture", 0, main_outs(), {9'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, E});
        @(negedge clk);
        upd = 1'b0; din = '0;
        @(negedge clk);
        done = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_done", 0, main_outs(), {9'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, E});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
